// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator.
// Produces hsync, vsync, display enable and line/frame strobes from a single
// pixel clock, together with scaled VRAM x/y read addresses. The sync/enable
// group is delayed by RD_LAT cycles so it lines up with the VRAM read data
// that the addresses produce.
//
// Pipeline:
//   p0 : raster counters and per-axis phase FSMs
//   p1 : registered addresses, addr_valid and undelayed timing
//   p2 : timing delayed by RD_LAT cycles (wire-through when RD_LAT == 0)
module vga_timing_gen #(
  parameter int   H_SYNC   = 192,
  parameter int   H_BP     = 96,
  parameter int   H_ACTIVE = 1280,
  parameter int   H_FP     = 32,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 29,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   SCALE_X  = 10,
  parameter int   SCALE_Y  = 5,
  parameter logic SYNC_POL = 1'b0,
  parameter int   RD_LAT   = 1,
  parameter int   XW       = 7,
  parameter int   YW       = 7
) (
  input  logic          clk,
  input  logic          reset,
  output logic [XW-1:0] x_addr,
  output logic [YW-1:0] y_addr,
  output logic          addr_valid,
  output logic          VGA_HSYNC,
  output logic          VGA_VSYNC,
  output logic          de,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  // Sub-step counters need at least one bit even when the scale is 1.
  localparam int SXW = (SCALE_X > 1) ? $clog2(SCALE_X) : 1;
  localparam int SYW = (SCALE_Y > 1) ? $clog2(SCALE_Y) : 1;

  // Last count of each horizontal phase.
  localparam logic [HW-1:0] H_SYNC_LAST = HW'(H_SYNC - 1);
  localparam logic [HW-1:0] H_BP_LAST   = HW'(H_SYNC + H_BP - 1);
  localparam logic [HW-1:0] H_ACT_FIRST = HW'(H_SYNC + H_BP);
  localparam logic [HW-1:0] H_ACT_LAST  = HW'(H_SYNC + H_BP + H_ACTIVE - 1);
  localparam logic [HW-1:0] H_LAST      = HW'(H_TOTAL - 1);

  // Last line of each vertical phase.
  localparam logic [VW-1:0] V_SYNC_LAST = VW'(V_SYNC - 1);
  localparam logic [VW-1:0] V_BP_LAST   = VW'(V_SYNC + V_BP - 1);
  localparam logic [VW-1:0] V_ACT_FIRST = VW'(V_SYNC + V_BP);
  localparam logic [VW-1:0] V_ACT_LAST  = VW'(V_SYNC + V_BP + V_ACTIVE - 1);
  localparam logic [VW-1:0] V_LAST      = VW'(V_TOTAL - 1);

  localparam logic [SXW-1:0] SX_LAST = SXW'(SCALE_X - 1);
  localparam logic [SYW-1:0] SY_LAST = SYW'(SCALE_Y - 1);

  // Phase encoding shared by both axes.
  localparam logic [1:0] ST_SYNC = 2'd0;
  localparam logic [1:0] ST_BP   = 2'd1;
  localparam logic [1:0] ST_ACT  = 2'd2;
  localparam logic [1:0] ST_FP   = 2'd3;

  // Timing bundle order: {hsync, vsync, de, line_start, frame_start}.
  localparam logic [4:0] TIM_RST = {SYNC_POL, SYNC_POL, 3'b000};

  // ---------------------------------------------------------------- p0
  logic [HW-1:0] hcnt_p0;
  logic [VW-1:0] vcnt_p0;
  logic [1:0]    hst_p0;
  logic [1:0]    vst_p0;
  logic [1:0]    hst_nxt;
  logic [1:0]    vst_nxt;
  logic          h_wrap;

  assign h_wrap = (hcnt_p0 == H_LAST);

  // Horizontal counter: free-running 0..H_TOTAL-1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hcnt_p0 <= '0;
    end else if (h_wrap) begin
      hcnt_p0 <= '0;
    end else begin
      hcnt_p0 <= hcnt_p0 + 1'b1;
    end
  end

  // Vertical counter: advances once per line, wraps after V_TOTAL lines.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vcnt_p0 <= '0;
    end else if (h_wrap) begin
      if (vcnt_p0 == V_LAST) begin
        vcnt_p0 <= '0;
      end else begin
        vcnt_p0 <= vcnt_p0 + 1'b1;
      end
    end
  end

  // Horizontal phase transitions happen on the last count of each phase.
  always_comb begin
    hst_nxt = hst_p0;
    case (hst_p0)
      ST_SYNC: if (hcnt_p0 == H_SYNC_LAST) hst_nxt = ST_BP;
      ST_BP:   if (hcnt_p0 == H_BP_LAST)   hst_nxt = ST_ACT;
      ST_ACT:  if (hcnt_p0 == H_ACT_LAST)  hst_nxt = ST_FP;
      default: if (h_wrap)                 hst_nxt = ST_SYNC;
    endcase
  end

  // Vertical phase transitions only at the end of a line.
  always_comb begin
    vst_nxt = vst_p0;
    if (h_wrap) begin
      case (vst_p0)
        ST_SYNC: if (vcnt_p0 == V_SYNC_LAST) vst_nxt = ST_BP;
        ST_BP:   if (vcnt_p0 == V_BP_LAST)   vst_nxt = ST_ACT;
        ST_ACT:  if (vcnt_p0 == V_ACT_LAST)  vst_nxt = ST_FP;
        default: if (vcnt_p0 == V_LAST)      vst_nxt = ST_SYNC;
      endcase
    end
  end

  // Phase state registers for both axes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hst_p0 <= ST_SYNC;
      vst_p0 <= ST_SYNC;
    end else begin
      hst_p0 <= hst_nxt;
      vst_p0 <= vst_nxt;
    end
  end

  // ---------------------------------------------------------------- p1
  logic          h_act;
  logic          v_act;
  logic [XW-1:0] x_addr_p1;
  logic [YW-1:0] y_addr_p1;
  logic [SXW-1:0] xsub_p1;
  logic [SYW-1:0] ysub_p1;
  logic          vld_p1;
  logic          hsync_p1;
  logic          vsync_p1;
  logic          ls_p1;
  logic          fs_p1;
  logic [4:0]    tim_p1;

  assign h_act = (hst_p0 == ST_ACT);
  assign v_act = (vst_p0 == ST_ACT);

  // Undelayed timing: syncs from the phase FSMs, strobes from the counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hsync_p1 <= SYNC_POL;
      vsync_p1 <= SYNC_POL;
      vld_p1   <= 1'b0;
      ls_p1    <= 1'b0;
      fs_p1    <= 1'b0;
    end else begin
      hsync_p1 <= (hst_p0 == ST_SYNC) ? SYNC_POL : ~SYNC_POL;
      vsync_p1 <= (vst_p0 == ST_SYNC) ? SYNC_POL : ~SYNC_POL;
      vld_p1   <= h_act && v_act;
      ls_p1    <= (hcnt_p0 == '0);
      fs_p1    <= (hcnt_p0 == '0) && (vcnt_p0 == '0);
    end
  end

  // Column address: restarts on the first active cycle, steps every SCALE_X
  // active cycles and holds its last value through horizontal blanking.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_addr_p1 <= '0;
      xsub_p1   <= '0;
    end else if (h_act) begin
      if (hcnt_p0 == H_ACT_FIRST) begin
        x_addr_p1 <= '0;
        xsub_p1   <= '0;
      end else if (xsub_p1 == SX_LAST) begin
        x_addr_p1 <= x_addr_p1 + 1'b1;
        xsub_p1   <= '0;
      end else begin
        xsub_p1   <= xsub_p1 + 1'b1;
      end
    end
  end

  // Row address: evaluated once per line at hcnt == 0; restarts on the first
  // active line, steps every SCALE_Y active lines, holds through blanking.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      y_addr_p1 <= '0;
      ysub_p1   <= '0;
    end else if (v_act && (hcnt_p0 == '0)) begin
      if (vcnt_p0 == V_ACT_FIRST) begin
        y_addr_p1 <= '0;
        ysub_p1   <= '0;
      end else if (ysub_p1 == SY_LAST) begin
        y_addr_p1 <= y_addr_p1 + 1'b1;
        ysub_p1   <= '0;
      end else begin
        ysub_p1   <= ysub_p1 + 1'b1;
      end
    end
  end

  assign tim_p1 = {hsync_p1, vsync_p1, vld_p1, ls_p1, fs_p1};

  // ---------------------------------------------------------------- p2
  logic [4:0] tim_p2;

  generate
    if (RD_LAT == 0) begin : g_nodly
      assign tim_p2 = tim_p1;
    end else begin : g_dly
      logic [4:0] dly_p2 [RD_LAT];

      // Shift register matching the VRAM read latency.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int i = 0; i < RD_LAT; i++) begin
            dly_p2[i] <= TIM_RST;
          end
        end else begin
          dly_p2[0] <= tim_p1;
          for (int i = 1; i < RD_LAT; i++) begin
            dly_p2[i] <= dly_p2[i-1];
          end
        end
      end

      assign tim_p2 = dly_p2[RD_LAT-1];
    end
  endgenerate

  assign x_addr     = x_addr_p1;
  assign y_addr     = y_addr_p1;
  assign addr_valid = vld_p1;
  assign {VGA_HSYNC, VGA_VSYNC, de, line_start, frame_start} = tim_p2;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen: one DUT with default geometry plus three
// small-geometry DUTs (RD_LAT=0, RD_LAT=3, SYNC_POL=1) sharing clock/reset.
// Expected values come from a closed-form function of the cycle index since
// reset release, plus directed hand-computed constants.
module tb_vga_timing_gen;

  typedef struct packed {
    int hs; int hb; int ha; int hf;
    int vs; int vb; int va; int vf;
    int sx; int sy; int pol; int lat;
  } geo_t;

  logic clk = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Default-geometry DUT
  logic [6:0] d_x, d_y;
  logic d_av, d_hs, d_vs, d_de, d_ls, d_fs;

  // Small-geometry DUTs: 0 = RD_LAT 0, 1 = RD_LAT 3, 2 = SYNC_POL 1 / RD_LAT 1
  logic [1:0] s_x [3];
  logic       s_y [3];
  logic s_av [3], s_hs [3], s_vs [3], s_de [3], s_ls [3], s_fs [3];

  vga_timing_gen u_def (
    .clk(clk), .reset(reset), .x_addr(d_x), .y_addr(d_y), .addr_valid(d_av),
    .VGA_HSYNC(d_hs), .VGA_VSYNC(d_vs), .de(d_de),
    .line_start(d_ls), .frame_start(d_fs)
  );

  vga_timing_gen #(
    .H_SYNC(3), .H_BP(2), .H_ACTIVE(8), .H_FP(2),
    .V_SYNC(2), .V_BP(1), .V_ACTIVE(6), .V_FP(1),
    .SCALE_X(2), .SCALE_Y(3), .SYNC_POL(1'b0), .RD_LAT(0), .XW(2), .YW(1)
  ) u_s0 (
    .clk(clk), .reset(reset), .x_addr(s_x[0]), .y_addr(s_y[0]), .addr_valid(s_av[0]),
    .VGA_HSYNC(s_hs[0]), .VGA_VSYNC(s_vs[0]), .de(s_de[0]),
    .line_start(s_ls[0]), .frame_start(s_fs[0])
  );

  vga_timing_gen #(
    .H_SYNC(3), .H_BP(2), .H_ACTIVE(8), .H_FP(2),
    .V_SYNC(2), .V_BP(1), .V_ACTIVE(6), .V_FP(1),
    .SCALE_X(2), .SCALE_Y(3), .SYNC_POL(1'b0), .RD_LAT(3), .XW(2), .YW(1)
  ) u_s3 (
    .clk(clk), .reset(reset), .x_addr(s_x[1]), .y_addr(s_y[1]), .addr_valid(s_av[1]),
    .VGA_HSYNC(s_hs[1]), .VGA_VSYNC(s_vs[1]), .de(s_de[1]),
    .line_start(s_ls[1]), .frame_start(s_fs[1])
  );

  vga_timing_gen #(
    .H_SYNC(3), .H_BP(2), .H_ACTIVE(8), .H_FP(2),
    .V_SYNC(2), .V_BP(1), .V_ACTIVE(6), .V_FP(1),
    .SCALE_X(2), .SCALE_Y(3), .SYNC_POL(1'b1), .RD_LAT(1), .XW(2), .YW(1)
  ) u_sp (
    .clk(clk), .reset(reset), .x_addr(s_x[2]), .y_addr(s_y[2]), .addr_valid(s_av[2]),
    .VGA_HSYNC(s_hs[2]), .VGA_VSYNC(s_vs[2]), .de(s_de[2]),
    .line_start(s_ls[2]), .frame_start(s_fs[2])
  );

  geo_t g_def;
  geo_t g_s [3];

  // Window counters
  int def_hs_low, def_de_hi, s0_fs, s0_ls, s0_vs_low, sp_hs_hi;

  // Undelayed timing {hs, vs, addr_valid, line_start, frame_start} for
  // counter index c (c = 0 is the value processed by the first edge).
  function automatic logic [4:0] tim(input geo_t g, input int c);
    int ht, vt, h, l;
    logic p, hact, vact;
    ht = g.hs + g.hb + g.ha + g.hf;
    vt = g.vs + g.vb + g.va + g.vf;
    p  = (g.pol != 0);
    if (c < 0) return {p, p, 3'b000};
    h = c % ht;
    l = (c / ht) % vt;
    hact = (h >= g.hs + g.hb) && (h < g.hs + g.hb + g.ha);
    vact = (l >= g.vs + g.vb) && (l < g.vs + g.vb + g.va);
    return {(h < g.hs) ? p : ~p, (l < g.vs) ? p : ~p, hact && vact,
            h == 0, (h == 0) && (l == 0)};
  endfunction

  function automatic int xa(input geo_t g, input int c);
    int ht, h, as;
    ht = g.hs + g.hb + g.ha + g.hf;
    as = g.hs + g.hb;
    if (c < 0) return 0;
    h = c % ht;
    if (h >= as && h < as + g.ha) return (h - as) / g.sx;
    if (c < as) return 0;
    return g.ha / g.sx - 1;
  endfunction

  function automatic int ya(input geo_t g, input int c);
    int ht, vt, l, vas;
    ht  = g.hs + g.hb + g.ha + g.hf;
    vt  = g.vs + g.vb + g.va + g.vf;
    vas = g.vs + g.vb;
    if (c < 0) return 0;
    l = (c / ht) % vt;
    if (l >= vas && l < vas + g.va) return (l - vas) / g.sy;
    if ((c / ht) < vas) return 0;
    return g.va / g.sy - 1;
  endfunction

  task automatic chk(input string tag, input int c, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s at c=%0d: observed %0h expected %0h", tag, c, obs, exp);
  endtask

  task automatic check_one(input string nm, input geo_t g, input int c,
                           input logic [31:0] ox, input logic [31:0] oy,
                           input logic oav, input logic [4:0] otim);
    logic [4:0] t1, t2;
    t1 = tim(g, c);
    t2 = tim(g, c - g.lat);
    chk({nm, ".x_addr"}, c, ox, xa(g, c));
    chk({nm, ".y_addr"}, c, oy, ya(g, c));
    chk({nm, ".addr_valid"}, c, {31'd0, oav}, {31'd0, t1[2]});
    chk({nm, ".hs_vs_de_ls_fs"}, c, {27'd0, otim}, {27'd0, t2});
  endtask

  task automatic check_all(input int c);
    check_one("def", g_def, c, d_x, d_y, d_av, {d_hs, d_vs, d_de, d_ls, d_fs});
    for (int i = 0; i < 3; i++) begin
      check_one($sformatf("s%0d", i), g_s[i], c, s_x[i], s_y[i], s_av[i],
                {s_hs[i], s_vs[i], s_de[i], s_ls[i], s_fs[i]});
    end
  endtask

  // Run n cycles after reset release, sampling on the falling edge.
  task automatic run(input int n);
    for (int k = 1; k <= n; k++) begin
      int c;
      @(negedge clk);
      c = k - 1;
      check_all(c);
      if (c >= 1 && c <= 1600 && d_hs === 1'b0) def_hs_low++;
      if (c >= 31*1600 + 1 && c <= 32*1600 && d_de === 1'b1) def_de_hi++;
      if (c < 450 && s_fs[0] === 1'b1) s0_fs++;
      if (c < 450 && s_ls[0] === 1'b1) s0_ls++;
      if (c < 150 && s_vs[0] === 1'b0) s0_vs_low++;
      if (c >= 1 && c <= 15 && s_hs[2] === 1'b1) sp_hs_hi++;
    end
  endtask

  initial begin
    g_def  = '{hs:192, hb:96, ha:1280, hf:32, vs:2, vb:29, va:480, vf:10,
               sx:10, sy:5, pol:0, lat:1};
    g_s[0] = '{hs:3, hb:2, ha:8, hf:2, vs:2, vb:1, va:6, vf:1,
               sx:2, sy:3, pol:0, lat:0};
    g_s[1] = g_s[0];
    g_s[1].lat = 3;
    g_s[2] = g_s[0];
    g_s[2].pol = 1;
    g_s[2].lat = 1;
    def_hs_low = 0; def_de_hi = 0; s0_fs = 0; s0_ls = 0; s0_vs_low = 0; sp_hs_hi = 0;

    // Held in reset across several edges: all outputs at reset values.
    repeat (3) @(negedge clk);
    check_all(-1);
    chk("sp.hsync_reset", -1, {31'd0, s_hs[2]}, 32'd1);
    chk("def.hsync_reset", -1, {31'd0, d_hs}, 32'd0);

    // Release on a falling edge; the next rising edge processes hcnt=vcnt=0.
    reset = 1'b1;
    run(52059);

    chk("def.hs_low_line0", 0, def_hs_low, 32'd192);
    chk("def.de_hi_line31", 0, def_de_hi, 32'd1280);
    chk("s0.frame_starts_3frames", 0, s0_fs, 32'd3);
    chk("s0.line_starts_3frames", 0, s0_ls, 32'd30);
    chk("s0.vs_low_frame0", 0, s0_vs_low, 32'd30);
    chk("sp.hs_high_line0", 0, sp_hs_hi, 32'd3);

    // Line 32, hcnt 858: mid-active at column 57.
    chk("def.x_addr_mid", 52058, d_x, 32'd57);
    chk("def.y_addr_mid", 52058, d_y, 32'd0);
    chk("def.de_mid", 52058, {31'd0, d_de}, 32'd1);

    // Asynchronous reset away from any rising edge.
    #2 reset = 1'b0;
    #1;
    chk("def.x_addr_async", -1, d_x, 32'd0);
    chk("def.addr_valid_async", -1, {31'd0, d_av}, 32'd0);
    chk("def.de_async", -1, {31'd0, d_de}, 32'd0);
    chk("def.hsync_async", -1, {31'd0, d_hs}, 32'd0);
    chk("def.vsync_async", -1, {31'd0, d_vs}, 32'd0);
    chk("sp.hsync_async", -1, {31'd0, s_hs[2]}, 32'd1);
    chk("sp.vsync_async", -1, {31'd0, s_vs[2]}, 32'd1);
    check_all(-1);

    // Restart: timing identical to the first release.
    @(negedge clk);
    reset = 1'b1;
    def_hs_low = 0;
    run(4800);
    chk("def.hs_low_line0_restart", 0, def_hs_low, 32'd192);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
